pc_fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, drives the synchronous instruction memory, and presents the IF/ID handoff (PC, instruction, valid) to decode. It is the consumer of the branch unit's redirect (`PC_sel`, `branch_PC`). It squashes wrong-path fetches, holds fetched instructions across hazard stalls, and traps misaligned branch targets.

---
 rtl/pc_fetch_unit_pkg.sv | 11 +
 rtl/pc_fetch_unit_if.sv | 21 ++
 rtl/pc_fetch_unit_instr_hold_reg.sv | 45 ++++
 rtl/pc_fetch_unit.sv | 105 ++++++++++
 tb/tb_pc_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory bus and IF/ID handoff between fetch and its neighbours.
interface pc_fetch_unit_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;
  logic             if_valid;

  modport master (
    output imem_addr, if_pc, if_instr, if_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr, if_pc, if_instr, if_valid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit_instr_hold_reg.sv
// Skid register: captures the presented instruction on the first stalled edge
// and keeps presenting it until the stall is released or flushed.
module instr_hold_reg #(
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [INS_W-1:0] rdata,
  output logic [INS_W-1:0] instr,
  output logic             held
);
  logic [INS_W-1:0] hold_q, hold_d;
  logic             held_q, held_d;

  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    if (flush) begin
      held_d = 1'b0;
    end else if (stall) begin
      // Only the first stalled edge captures; memory has moved on after that.
      if (!held_q) begin
        hold_d = rdata;
        held_d = 1'b1;
      end
    end else begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      held_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end

  assign instr = held_q ? hold_q : rdata;
  assign held  = held_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory, handles redirects, hazard stalls and misaligned-target trapping.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_sel,
  input  logic [31:0]       branch_PC,
  input  logic              stall,
  input  logic              err_clear,
  output logic              misalign_err,
  pc_fetch_unit_if.master   bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            fetch_vld_q, fetch_vld_d;
  logic            err_q, err_d;
  logic            flush, hold_stall;
  logic [INS_W-1:0] rdata_sel;
  logic            unused_held;
  logic            unused_branch_hi;

  assign unused_branch_hi = ^branch_PC[31:PC_W];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    fetch_vld_d = fetch_vld_q;
    err_d       = err_q;
    flush       = 1'b0;
    hold_stall  = 1'b0;
    unique case (state_q)
      BOOT, RUN: begin
        state_d = RUN;
        if (PC_sel) begin
          // Redirect beats stall; the in-flight fetch is on the wrong path.
          flush       = 1'b1;
          fetch_vld_d = 1'b0;
          if (branch_PC[1:0] == 2'b00) begin
            pc_d = branch_PC[PC_W-1:0];
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end else if (stall && (state_q == RUN)) begin
          hold_stall = 1'b1;
        end else begin
          pc_d        = pc_q + PC_W'(PC_STEP);
          fetch_pc_d  = pc_q;
          fetch_vld_d = 1'b1;
        end
      end
      ERR: begin
        fetch_vld_d = 1'b0;
        if (err_clear) begin
          pc_d    = RESET_PC;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      fetch_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      fetch_vld_q <= fetch_vld_d;
      err_q       <= err_d;
    end
  end

  // Memory data is only meaningful when a fetch was issued last cycle.
  assign rdata_sel = fetch_vld_q ? bus.imem_rdata : INS_W'(NOP_INSTR);

  instr_hold_reg #(.INS_W(INS_W)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (hold_stall),
    .flush (flush),
    .rdata (rdata_sel),
    .instr (bus.if_instr),
    .held  (unused_held)
  );

  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = fetch_pc_q;
  assign bus.if_valid  = fetch_vld_q && (state_q != ERR);
  assign misalign_err  = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level fetch model checked
// every cycle, plus literal expectations for reset, wrap, stall, redirect, trap.
module tb_pc_fetch_unit;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PC_sel;
  logic [31:0] branch_PC;
  logic        stall;
  logic        err_clear;
  logic        misalign_err;

  pc_fetch_unit_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

  pc_fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC('0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_sel       (PC_sel),
    .branch_PC    (branch_PC),
    .stall        (stall),
    .err_clear    (err_clear),
    .misalign_err (misalign_err),
    .bus          (bus)
  );

  logic [31:0] mem [0:127];
  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[8:2]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural model: next address to fetch and the presented entry.
  logic [8:0] m_next, m_pc;
  bit         m_vld, m_err, m_boot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1; m_err <= 0; m_next <= 9'd0; m_vld <= 0; m_pc <= 9'd0;
    end else begin
      m_boot <= 0;
      if (m_err) begin
        if (err_clear) begin
          m_err  <= 0;
          m_next <= 9'd0;
        end
      end else if (PC_sel) begin
        m_vld <= 0;
        if (branch_PC[1:0] == 2'b00) m_next <= branch_PC[8:0];
        else                         m_err  <= 1;
      end else if (!(stall && !m_boot)) begin
        m_pc   <= m_next;
        m_vld  <= 1;
        m_next <= m_next + 9'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_addr",  32'(bus.imem_addr), 32'(m_next));
      check("model_valid", 32'(bus.if_valid),  32'(m_vld && !m_err));
      check("model_err",   32'(misalign_err),  32'(m_err));
      if (m_vld && !m_err) begin
        check("model_pc",    32'(bus.if_pc), 32'(m_pc));
        check("model_instr", bus.if_instr,   mem[m_pc[8:2]]);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_entry(input string nm, input logic [8:0] pc);
    check({nm, "_valid"}, 32'(bus.if_valid), 32'd1);
    check({nm, "_pc"},    32'(bus.if_pc),    32'(pc));
    check({nm, "_instr"}, bus.if_instr,      mem[pc[8:2]]);
  endtask

  task automatic expect_reset_outputs(input string nm);
    check({nm, "_valid"}, 32'(bus.if_valid),  32'd0);
    check({nm, "_pc"},    32'(bus.if_pc),     32'd0);
    check({nm, "_instr"}, bus.if_instr,       NOP);
    check({nm, "_err"},   32'(misalign_err),  32'd0);
    check({nm, "_addr"},  32'(bus.imem_addr), 32'd0);
  endtask

  task automatic wait_pc(input logic [8:0] pc, input string nm);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.if_valid && bus.if_pc == pc) begin
        found = 1;
        break;
      end
      cyc();
    end
    check({nm, "_reached"}, 32'(found), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0003;
    rst_n = 1; PC_sel = 0; branch_PC = '0; stall = 0; err_clear = 0;
    #2 rst_n = 0;
    #1 expect_reset_outputs("por");
    chk_en = 1;
    repeat (2) cyc();
    rst_n = 1;

    // Boot: first valid entry one cycle after the first fetch edge.
    cyc(); expect_entry("boot0", 9'h000);
    cyc(); expect_entry("boot1", 9'h004);
    cyc(); expect_entry("boot2", 9'h008);

    // Stall while 0x010 is presented.
    wait_pc(9'h010, "stall_wait");
    expect_entry("stall_a", 9'h010);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_entry("stall_hold", 9'h010);
    end
    stall = 0;
    cyc(); expect_entry("stall_resume", 9'h014);

    // Redirect to 0x40: one bubble, then target.
    PC_sel = 1; branch_PC = 32'h0000_0040;
    cyc(); PC_sel = 0;
    check("redir_bubble", 32'(bus.if_valid), 32'd0);
    check("redir_addr", 32'(bus.imem_addr), 32'h40);
    cyc(); expect_entry("redir_tgt", 9'h040);
    cyc(); expect_entry("redir_next", 9'h044);

    // Redirect while stalled with a held entry.
    stall = 1;
    cyc();
    PC_sel = 1; branch_PC = 32'h0000_0080;
    cyc(); PC_sel = 0; stall = 0;
    check("rds_bubble", 32'(bus.if_valid), 32'd0);
    cyc(); expect_entry("rds_tgt", 9'h080);

    // Wrap, with upper target bits that must be ignored.
    PC_sel = 1; branch_PC = 32'hFFFF_FFF8;
    cyc(); PC_sel = 0;
    check("wrap_addr", 32'(bus.imem_addr), 32'h1F8);
    cyc(); expect_entry("wrap0", 9'h1F8);
    cyc(); expect_entry("wrap1", 9'h1FC);
    cyc(); expect_entry("wrap2", 9'h000);
    cyc(); expect_entry("wrap3", 9'h004);

    // Misaligned target traps; redirects and stalls are ignored in the trap.
    PC_sel = 1; branch_PC = 32'h0000_0042;
    cyc(); PC_sel = 0;
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_valid", 32'(bus.if_valid), 32'd0);
    PC_sel = 1; branch_PC = 32'h0000_0100; stall = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("mis_hold_err", 32'(misalign_err), 32'd1);
      check("mis_hold_valid", 32'(bus.if_valid), 32'd0);
    end
    PC_sel = 0; stall = 0;
    cyc();
    check("mis_still_err", 32'(misalign_err), 32'd1);
    err_clear = 1;
    cyc(); err_clear = 0;
    check("clr_err", 32'(misalign_err), 32'd0);
    check("clr_valid", 32'(bus.if_valid), 32'd0);
    check("clr_addr", 32'(bus.imem_addr), 32'd0);
    cyc(); expect_entry("clr_first", 9'h000);
    cyc(); expect_entry("clr_second", 9'h004);

    // Asynchronous reset mid-run.
    repeat (3) cyc();
    #2 rst_n = 0;
    #1 expect_reset_outputs("mid_rst");
    cyc(); rst_n = 1;
    cyc(); expect_entry("rst_first", 9'h000);
    cyc(); expect_entry("rst_second", 9'h004);
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
